// File: rtl/mips16_pkg.sv
// mips16_pkg: shared state, opcode and mux-select encodings for the multi-cycle control FSM
package mips16_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_J    = 4'd5;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] B_REG = 2'd0;
    localparam logic [1:0] B_ONE = 2'd1;
    localparam logic [1:0] B_IMM = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // States that hold mem_req and wait on mem_ready
    function automatic logic is_mem(input state_t s);
        return s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR;
    endfunction

endpackage

// File: rtl/mips16_mem_wait_timer.sv
// mips16_mem_wait_timer: counts memory wait cycles and flags the cycle that reaches MEM_TIMEOUT
//  clk, rst     clock, asynchronous active-high reset
//  active       FSM is in a memory-access state
//  mem_ready    memory completes the access this cycle
//  timeout      this is the MEM_TIMEOUT-th consecutive wait cycle (never set if MEM_TIMEOUT == 0)
module mips16_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);
    localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    logic [W-1:0] cnt;

    // mem_ready wins over a coincident timeout because a ready cycle is not a wait cycle
    assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && cnt == W'(MEM_TIMEOUT - 1);

    // Every memory state is left on mem_ready or timeout, so clearing on those (and outside
    // memory states) guarantees the count starts at zero on each entry, including FETCH->FETCH.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else
            cnt <= (active && !mem_ready && !timeout) ? cnt + 1'b1 : '0;

endmodule

// File: rtl/mips16_mc_ctrl.sv
// mips16_mc_ctrl: multi-cycle control FSM for the 16-bit MIPS datapath
//  Inputs : clk, rst (async, active-high), opcode[3:0] (IR[15:12]), mem_ready, zero (ALU flag)
//  Outputs: mem_req, mem_we, iord, ir_we, pc_we, pc_src[1:0], alu_src_a, alu_src_b[1:0],
//           alu_op[1:0], reg_we, reg_dst, mem_to_reg, mem_err (timeout pulse), state[3:0]
//  MIPS16_TRAP_EN: when defined adds output trap; illegal opcodes lock in TRAP until rst.
//                  When undefined an illegal opcode behaves as a NOP.
module mips16_mc_ctrl
    import mips16_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       mem_err,
    output logic [3:0] state
`ifdef MIPS16_TRAP_EN
    ,
    output logic       trap
`endif
);

    state_t st;
    logic   timeout;

    mips16_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .active    (is_mem(st)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            st <= S_FETCH;
        else
            case (st)
                S_FETCH:  if (mem_ready) st <= S_DECODE;
                S_DECODE:
                    case (opcode)
                        OP_R:                   st <= S_EXEC_R;
                        OP_ADDI, OP_LW, OP_SW:  st <= S_EXEC_I;
                        OP_BEQ:                 st <= S_BRANCH;
                        OP_J:                   st <= S_JUMP;
`ifdef MIPS16_TRAP_EN
                        default:                st <= S_TRAP;
`else
                        default:                st <= S_FETCH;
`endif
                    endcase
                S_EXEC_R: st <= S_WB_R;
                S_EXEC_I: st <= opcode == OP_ADDI ? S_WB_I : opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: if (mem_ready) st <= S_WB_MEM; else if (timeout) st <= S_FETCH;
                S_MEM_WR: if (mem_ready || timeout) st <= S_FETCH;
                S_TRAP:   st <= S_TRAP;
                default:  st <= S_FETCH;
            endcase

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = B_REG;
        alu_op     = ALU_ADD;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (st)
            S_FETCH: begin
                mem_req   = 1'b1;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                alu_src_b = B_ONE;
            end
            S_DECODE: alu_src_b = B_IMM;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_WB_R: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = B_IMM;
            end
            S_WB_I: reg_we = 1'b1;
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_WB_MEM: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_we     = zero;
            end
            S_JUMP: begin
                pc_src = PC_JUMP;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
        // Reset must cancel an in-flight access immediately, not at the next clock edge
        if (rst)
            {mem_req, mem_we, ir_we, pc_we, reg_we} = '0;
    end

    assign mem_err = timeout && !rst;
    assign state   = st;

`ifdef MIPS16_TRAP_EN
    assign trap = st == S_TRAP;
`endif

endmodule
